// File: rtl/axi_ic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ic_pkg
// Description : Shared types and helpers for the AXI interconnect arbiters
//               (write-channel and read-channel).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ic_pkg;

  // Largest number of masters an arbiter instance is built for.
  localparam int C_N_MST_MAX = 8;

  // Arbiter transaction state. Encoded explicitly so both arbiters agree.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Width of a binary master index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : axi_rr_pick
// Description : Combinational N-way rotating-priority picker. The search
//               begins at i_ptr and wraps modulo N; the first asserted request
//               wins. Returns one-hot grant, binary index and an any flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rr_pick
  import axi_ic_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int            w_sum;
  logic [IW-1:0] w_pos;

  // Walk the requests from i_ptr upward with wrap; keep the first hit only.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = 0;
    w_pos = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= N) begin
        w_sum = w_sum - N;
      end
      w_pos = IW'(w_sum);
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_arbiter_w_rr.sv
`default_nettype none
// ============================================================================
// Module      : axi_arbiter_w_rr
// Description : Round-robin write-channel arbiter for one slave port. Holds a
//               registered one-hot grant for a whole write transaction
//               (AW handshake, W through WLAST, B handshake), then releases or
//               hands over to the next requester with no idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_arbiter_w_rr
  import axi_ic_pkg::*;
#(
  parameter int N_MST = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [N_MST-1:0]         s_awvalid,
  input  logic [N_MST-1:0]         s_wvalid,
  input  logic [N_MST-1:0]         s_wlast,
  input  logic [N_MST-1:0]         s_bready,
  input  logic                     m_awready,
  input  logic                     m_wready,
  input  logic                     m_bvalid,
  output logic [N_MST-1:0]         wgrnt,
  output logic [$clog2(N_MST)-1:0] wgrnt_idx,
  output logic                     busy
);

  localparam int C_IW = idx_width(N_MST);

  arb_state_e       r_state,     w_state_nxt;
  logic [N_MST-1:0] r_wgrnt,     w_wgrnt_nxt;
  logic [C_IW-1:0]  r_idx,       w_idx_nxt;
  logic [C_IW-1:0]  r_ptr,       w_ptr_nxt;
  logic             r_aw_done,   w_aw_done_nxt;
  logic             r_w_done,    w_w_done_nxt;

  logic [N_MST-1:0] w_pick_gnt;
  logic [C_IW-1:0]  w_pick_idx;
  logic             w_pick_any;
  logic [C_IW-1:0]  w_ptr_adv;

  logic             w_aw_evt;
  logic             w_w_evt;
  logic             w_b_evt;

  axi_rr_pick #(
    .N  (N_MST),
    .IW (C_IW)
  ) u_pick (
    .i_req (s_awvalid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Pointer moves to the slot after the winner so it has lowest priority next.
  assign w_ptr_adv = (w_pick_idx == C_IW'(N_MST - 1)) ? '0 : w_pick_idx + 1'b1;

  // Only the granted master's handshakes count; other masters are masked out.
  assign w_aw_evt = (|(s_awvalid & r_wgrnt)) & m_awready;
  assign w_w_evt  = (|(s_wvalid & s_wlast & r_wgrnt)) & m_wready;
  assign w_b_evt  = m_bvalid & (|(s_bready & r_wgrnt));

  // Next-state and next-grant decode for the IDLE/XFER/RESP sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_wgrnt_nxt   = r_wgrnt;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt   = XFER;
          w_wgrnt_nxt   = w_pick_gnt;
          w_idx_nxt     = w_pick_idx;
          w_ptr_nxt     = w_ptr_adv;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      XFER: begin
        // W may finish before AW; both may finish in the same cycle.
        w_aw_done_nxt = r_aw_done | w_aw_evt;
        w_w_done_nxt  = r_w_done  | w_w_evt;
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_b_evt) begin
          if (w_pick_any) begin
            w_state_nxt   = XFER;
            w_wgrnt_nxt   = w_pick_gnt;
            w_idx_nxt     = w_pick_idx;
            w_ptr_nxt     = w_ptr_adv;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
          end else begin
            w_state_nxt   = IDLE;
            w_wgrnt_nxt   = '0;
            w_idx_nxt     = '0;
          end
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_wgrnt_nxt   = '0;
        w_idx_nxt     = '0;
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State, grant, pointer and completion flags; reset drops the grant at once.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_wgrnt   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wgrnt   <= w_wgrnt_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  assign wgrnt     = r_wgrnt;
  assign wgrnt_idx = r_idx;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_arbiter_w_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_arbiter_w_rr
// Description : Directed self-checking bench for axi_arbiter_w_rr (N_MST=4).
//               Expected grants are queued as stimulus is driven and popped
//               whenever a new grant appears on wgrnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_arbiter_w_rr;

  localparam int N = 4;

  logic         ACLK;
  logic         ARESETn;
  logic [N-1:0] s_awvalid;
  logic [N-1:0] s_wvalid;
  logic [N-1:0] s_wlast;
  logic [N-1:0] s_bready;
  logic         m_awready;
  logic         m_wready;
  logic         m_bvalid;
  logic [N-1:0] wgrnt;
  logic [1:0]   wgrnt_idx;
  logic         busy;

  int           n_cmp;
  int           n_err;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_grnt;

  axi_arbiter_w_rr #(.N_MST(N)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .s_awvalid (s_awvalid),
    .s_wvalid  (s_wvalid),
    .s_wlast   (s_wlast),
    .s_bready  (s_bready),
    .m_awready (m_awready),
    .m_wready  (m_wready),
    .m_bvalid  (m_bvalid),
    .wgrnt     (wgrnt),
    .wgrnt_idx (wgrnt_idx),
    .busy      (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each newly appearing non-zero grant must match the queue head.
  initial prev_grnt = '0;
  always @(negedge ACLK) begin
    if (wgrnt !== prev_grnt && wgrnt !== '0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_grant", 32'(wgrnt), 32'h0);
      end else begin
        chk("sb_grant_order", 32'(wgrnt), 32'(exp_q.pop_front()));
      end
    end
    prev_grnt = wgrnt;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clr();
    s_awvalid = '0;
    s_wvalid  = '0;
    s_wlast   = '0;
    s_bready  = '0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    ARESETn = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    ARESETn = 1'b0;
    clr();
    tick();
    chk("rst_wgrnt", 32'(wgrnt), 32'h0);
    chk("rst_idx",   32'(wgrnt_idx), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    ARESETn = 1'b1;
    tick();

    // ---- Single master 2, 4-beat burst --------------------------------------
    exp_q.push_back(4'b0100);
    s_awvalid = 4'b0100;
    tick();
    chk("m2_grant",   32'(wgrnt), 32'h4);
    chk("m2_idx",     32'(wgrnt_idx), 32'h2);
    chk("m2_busy",    32'(busy), 32'h1);
    m_awready = 1'b1;
    m_wready  = 1'b1;
    s_wvalid  = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      s_wlast = (i == 3) ? 4'b0100 : 4'b0000;
      tick();
      s_awvalid = '0;
      m_awready = 1'b0;
      chk("m2_hold", 32'(wgrnt), 32'h4);
    end
    clr();
    m_bvalid = 1'b1;
    s_bready = 4'b0100;
    tick();
    clr();
    chk("m2_rel_grant", 32'(wgrnt), 32'h0);
    chk("m2_rel_busy",  32'(busy), 32'h0);
    chk("m2_rel_idx",   32'(wgrnt_idx), 32'h0);

    // ---- All four request, 1-beat writes, order 0,1,2,3,0 -------------------
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    s_awvalid = 4'b1111;
    s_wvalid  = 4'b1111;
    s_wlast   = 4'b1111;
    s_bready  = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(wgrnt), 32'(1 << (k % 4)));
      chk("rr_busy",  32'(busy), 32'h1);
      m_awready = 1'b1;
      m_wready  = 1'b1;
      m_bvalid  = 1'b0;
      tick();
      chk("rr_resp_hold", 32'(wgrnt), 32'(1 << (k % 4)));
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b1;
      if (k == 4) s_awvalid = '0;
      tick();
    end
    clr();
    chk("rr_end_grant", 32'(wgrnt), 32'h0);
    chk("rr_end_busy",  32'(busy), 32'h0);

    // ---- Master 1: W with WLAST before AW; B during XFER ignored ------------
    do_reset();
    exp_q.push_back(4'b0010);
    s_awvalid = 4'b0010;
    tick();
    chk("m1_grant", 32'(wgrnt), 32'h2);
    s_wvalid = 4'b0010;
    m_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_wlast = (i == 2) ? 4'b0010 : 4'b0000;
      tick();
      chk("m1_wfirst_hold", 32'(wgrnt), 32'h2);
    end
    s_wvalid = '0;
    s_wlast  = '0;
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    s_bready = 4'b0010;
    tick();
    chk("m1_early_b_hold", 32'(wgrnt), 32'h2);
    chk("m1_early_b_busy", 32'(busy), 32'h1);
    m_bvalid  = 1'b0;
    m_awready = 1'b1;
    tick();
    s_awvalid = '0;
    m_awready = 1'b0;
    chk("m1_resp_hold", 32'(wgrnt), 32'h2);
    m_bvalid = 1'b1;
    tick();
    clr();
    chk("m1_rel", 32'(wgrnt), 32'h0);

    // ---- Master 3 holds grant while master 0 requests mid-burst -------------
    do_reset();
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    s_awvalid = 4'b1000;
    tick();
    chk("m3_grant", 32'(wgrnt), 32'h8);
    m_awready = 1'b1;
    m_wready  = 1'b1;
    s_wvalid  = 4'b1000;
    s_awvalid = 4'b1001;
    tick();
    chk("m3_hold_b1", 32'(wgrnt), 32'h8);
    s_awvalid = 4'b0001;
    m_awready = 1'b0;
    s_wvalid  = 4'b0000;
    m_bvalid  = 1'b1;
    s_bready  = 4'b1111;
    tick();
    chk("m3_bpulse_hold", 32'(wgrnt), 32'h8);
    m_bvalid = 1'b0;
    s_wvalid = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      s_wlast = (i == 1) ? 4'b1000 : 4'b0000;
      tick();
      chk("m3_hold_burst", 32'(wgrnt), 32'h8);
    end
    s_wvalid = '0;
    s_wlast  = '0;
    m_wready = 1'b0;
    tick();
    chk("m3_resp_wait", 32'(wgrnt), 32'h8);
    m_bvalid = 1'b1;
    s_bready = 4'b1000;
    tick();
    chk("m0_handover",      32'(wgrnt), 32'h1);
    chk("m0_handover_busy", 32'(busy), 32'h1);
    chk("m0_handover_idx",  32'(wgrnt_idx), 32'h0);
    m_bvalid  = 1'b0;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    s_wvalid  = 4'b0001;
    s_wlast   = 4'b0001;
    tick();
    clr();
    m_bvalid = 1'b1;
    s_bready = 4'b0001;
    tick();
    clr();
    chk("m0_rel", 32'(wgrnt), 32'h0);

    // ---- Reset asserted during RESP ------------------------------------------
    do_reset();
    exp_q.push_back(4'b0100);
    s_awvalid = 4'b0100;
    tick();
    chk("rr6_grant", 32'(wgrnt), 32'h4);
    m_awready = 1'b1;
    m_wready  = 1'b1;
    s_wvalid  = 4'b0100;
    s_wlast   = 4'b0100;
    tick();
    clr();
    chk("rr6_resp_busy", 32'(busy), 32'h1);
    ARESETn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(wgrnt), 32'h0);
    chk("async_rst_busy",  32'(busy), 32'h0);
    tick();
    exp_q.push_back(4'b0001);
    s_awvalid = 4'b1001;
    ARESETn   = 1'b1;
    tick();
    chk("post_rst_ptr0", 32'(wgrnt), 32'h1);
    clr();
    tick();
    tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
